// File: rtl/n_to_one_mux_arb_pkg.sv
// mux_pkg: mode encodings and select-width helper shared by the mux/arbiter blocks.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/n_to_one_mux_arb_rr_priority_picker.sv
// rr_priority_picker: first set request at or after the pointer, wrapping around.
module rr_priority_picker
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_grant,
  output logic             o_grant_valid
);
  int j;
  always_comb begin
    o_grant = '0;
    o_grant_valid = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(i_ptr) + i;
      j = (j >= N) ? j - N : j;
      if (!o_grant_valid && i_req[j]) begin
        o_grant = SEL_W'(j);
        o_grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/n_to_one_mux_arb.sv
// n_to_one_mux_arb: N-channel valid/ready mux with fixed or round-robin selection
// feeding a single registered output stage.
module n_to_one_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_rr_g;
  logic             w_rr_v;
  logic [N-1:0]     w_req_sh;
  logic             w_fix_v;
  logic [SEL_W-1:0] w_gnt;
  logic             w_gnt_v;
  logic             w_can_load;
  logic             w_xfer;

  rr_priority_picker #(.N(N)) u_pick (
    .i_req(in_valid),
    .i_ptr(r_ptr),
    .o_grant(w_rr_g),
    .o_grant_valid(w_rr_v)
  );

  // Out-of-range sel (non power-of-2 N) simply yields no grant.
  assign w_req_sh = in_valid >> sel;
  assign w_fix_v = (int'(sel) < N) && w_req_sh[0];
  assign w_gnt = (mode == MODE_RR) ? w_rr_g : sel;
  assign w_gnt_v = (mode == MODE_RR) ? w_rr_v : w_fix_v;
  assign w_can_load = ~out_valid | out_ready;
  assign w_xfer = w_gnt_v & w_can_load & ~reset;
  assign in_ready = w_xfer ? N'(1) << w_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      r_ptr <= '0;
    end else begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data <= in_data[w_gnt*WIDTH +: WIDTH];
        out_chan <= w_gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_xfer && mode == MODE_RR)
        r_ptr <= (w_gnt == SEL_W'(N - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_n_to_one_mux_arb.sv
// tb_n_to_one_mux_arb: directed checks of the mux/arbiter on a 4-channel and a 3-channel instance.
module tb_n_to_one_mux_arb;
  logic         clk = 0;
  logic         reset = 1;
  logic         a_mode = 0;
  logic [1:0]   a_sel = 0;
  logic [3:0]   a_in_valid = 0;
  logic [127:0] a_in_data = 0;
  logic [3:0]   a_in_ready;
  logic         a_out_valid;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_chan;
  logic         a_out_ready = 0;
  logic         b_mode = 0;
  logic [1:0]   b_sel = 0;
  logic [2:0]   b_in_valid = 0;
  logic [95:0]  b_in_data = 0;
  logic [2:0]   b_in_ready;
  logic         b_out_valid;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_chan;
  logic         b_out_ready = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  n_to_one_mux_arb #(.WIDTH(32), .N(4)) dut_a (
    .clk(clk), .reset(reset), .mode(a_mode), .sel(a_sel),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_ready(a_out_ready)
  );

  n_to_one_mux_arb #(.WIDTH(32), .N(3)) dut_b (
    .clk(clk), .reset(reset), .mode(b_mode), .sel(b_sel),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_mode = 0;
    a_sel = 0;
    a_in_valid = 4'b1111;
    #1;
    check("rst_ready", a_in_ready, 4'b0000);
    check("rst_valid", a_out_valid, 0);
    #2 reset = 0;
    a_in_valid = 4'b0001;
    a_in_data[31:0] = 32'hA5A5A5A5;
    a_out_ready = 0;
    tick();
    check("load_valid", a_out_valid, 1);
    check("load_data", a_out_data, 32'hA5A5A5A5);
    a_in_valid = 4'b1111;
    a_out_ready = 1;
    #2 reset = 1;
    #1;
    check("arst_valid", a_out_valid, 0);
    check("arst_data", a_out_data, 0);
    check("arst_chan", a_out_chan, 0);
    check("arst_ready", a_in_ready, 4'b0000);
    #1 reset = 0;
    a_in_valid = 0;
    tick();
    check("post_rst_valid", a_out_valid, 0);

    for (int i = 0; i < 4; i++) a_in_data[i*32 +: 32] = 32'h10 + i;
    a_in_valid = 4'b1111;
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      #1;
      check("fix_ready", a_in_ready, 4'b0001 << i);
      tick();
      check("fix_valid", a_out_valid, 1);
      check("fix_data", a_out_data, 32'h10 + i);
      check("fix_chan", a_out_chan, i);
    end

    a_mode = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_chan", a_out_chan, k % 4);
      check("rr_data", a_out_data, 32'h10 + (k % 4));
    end
    a_in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_alt_chan", a_out_chan, (k % 2 == 0) ? 1 : 3);
    end

    a_in_valid = 0;
    tick();
    check("drain_valid", a_out_valid, 0);
    a_in_valid = 4'b0110;
    a_out_ready = 0;
    tick();
    check("bp_first_chan", a_out_chan, 1);
    check("bp_first_valid", a_out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", a_in_ready, 4'b0000);
      tick();
      check("bp_chan", a_out_chan, 1);
      check("bp_data", a_out_data, 32'h11);
      check("bp_valid", a_out_valid, 1);
    end
    a_out_ready = 1;
    #1;
    check("bp_release_ready", a_in_ready, 4'b0100);
    tick();
    check("bp_pop_valid", a_out_valid, 1);
    check("bp_pop_chan", a_out_chan, 2);
    check("bp_pop_data", a_out_data, 32'h12);

    a_in_valid = 4'b1001;
    #1;
    check("wrap_ready", a_in_ready, 4'b1000);
    tick();
    check("wrap_chan", a_out_chan, 3);
    a_mode = 0;
    a_sel = 3;
    #1;
    check("sw_fix_ready", a_in_ready, 4'b1000);
    tick();
    check("sw_fix_chan", a_out_chan, 3);
    a_mode = 1;
    #1;
    check("sw_rr_ready", a_in_ready, 4'b0001);
    tick();
    check("sw_rr_chan", a_out_chan, 0);
    check("sw_rr_data", a_out_data, 32'h10);

    for (int i = 0; i < 3; i++) b_in_data[i*32 +: 32] = 32'h20 + i;
    b_mode = 0;
    b_sel = 3;
    b_in_valid = 3'b111;
    b_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("oor_ready", b_in_ready, 3'b000);
      tick();
      check("oor_valid", b_out_valid, 0);
    end
    b_sel = 2;
    #1;
    check("n3_ready", b_in_ready, 3'b100);
    tick();
    check("n3_valid", b_out_valid, 1);
    check("n3_data", b_out_data, 32'h22);
    check("n3_chan", b_out_chan, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
